// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer: bus geometry defaults
// and the transfer FSM state type.
package apb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;
    localparam int APB_DEPTH  = 64;

    // IDLE waits for a setup phase; ACCESS counts wait states and completes.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    // Width of a down-counter that must hold the value n (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W register array: synchronous clear, one write port,
// one combinational read port.
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DEPTH  = APB_DEPTH,
    parameter int DATA_W = APB_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: reset clears every word, otherwise commit the single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so data is available in the completing access cycle.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/apb_mem_completer.sv
// APB completer fronting a small register array. Tracks setup/access
// phases, stretches each access by WAIT_CYCLES through PREADY, flags
// out-of-range addresses through PSLVERR and commits writes on completion.
module apb_mem_completer
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = APB_DEPTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int                AW        = $clog2(DEPTH);
    localparam int                CNT_W     = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    // One extra bit so DEPTH itself is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    apb_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              load;
    logic              err;
    logic              we;
    logic [DATA_W-1:0] mem_rdata;

    // Range check on the full latched address; no aliasing into the array.
    always_comb begin
        err = ({1'b0, addr_q} >= DEPTH_EXT);
    end

    // Next-state logic: setup detection, wait countdown, completion and abort.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        PREADY  = 1'b0;
        case (state)
            IDLE: begin
                // PSEL&PENABLE without a prior setup is ignored here.
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;               // abort, nothing commits
                end else if (!PENABLE) begin
                    load    = 1'b1;               // fresh setup restarts the transfer
                    cnt_d   = WAIT_LOAD;
                end else if (cnt != '0) begin
                    cnt_d   = cnt - CNT_W'(1);
                end else begin
                    PREADY  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and setup-phase latches.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
            end
        end
    end

    // Writes commit only on a good completion; PWDATA is taken at that edge.
    always_comb begin
        we = PREADY && write_q && !err;
    end

    apb_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we),
        .waddr (addr_q[AW-1:0]),
        .wdata (PWDATA),
        .raddr (addr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Response muxing: data and error only while the transfer completes.
    always_comb begin
        PSLVERR = PREADY && err;
        PRDATA  = (PREADY && !write_q && !err) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: two instances (one wait state / zero wait),
// a transaction-level model of the array and expected bus responses, a
// per-cycle compare process, plus literal checks on key results.
module tb_apb_mem_completer;

    logic       clk = 1'b0;
    logic [1:0] rst, sel, en, wr;
    logic [8:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] prdata [2];
    logic       rdy0, rdy1, perr0, perr1;
    logic [1:0] rdy, perr;

    // expectations, set by the driver each cycle from the transaction model
    logic [1:0] exp_rdy, exp_err;
    logic [7:0] exp_rd [2];
    logic [7:0] mem_m [2][64];
    logic       chk = 1'b0;

    int vectors = 0;
    int miss    = 0;

    always #5 clk = ~clk;

    assign rdy  = {rdy1, rdy0};
    assign perr = {perr1, perr0};

    apb_mem_completer #(.WAIT_CYCLES(1)) u_w1 (
        .PCLK(clk), .PRESET(rst[0]), .PSEL(sel[0]), .PENABLE(en[0]), .PWRITE(wr[0]),
        .PADDR(addr[0]), .PWDATA(wdata[0]), .PRDATA(prdata[0]), .PREADY(rdy0), .PSLVERR(perr0)
    );

    apb_mem_completer #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESET(rst[1]), .PSEL(sel[1]), .PENABLE(en[1]), .PWRITE(wr[1]),
        .PADDR(addr[1]), .PWDATA(wdata[1]), .PRDATA(prdata[1]), .PREADY(rdy1), .PSLVERR(perr1)
    );

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (rdy[d] !== exp_rdy[d] || perr[d] !== exp_err[d] || prdata[d] !== exp_rd[d]) begin
                    miss++;
                    $display("FAIL cycle d%0d t=%0t: rdy/err/rdata got %b/%b/%02h want %b/%b/%02h",
                             d, $time, rdy[d], perr[d], prdata[d], exp_rdy[d], exp_err[d], exp_rd[d]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miss++;
            $display("FAIL %s: got %02h want %02h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int d);
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        exp_rd[d]  = 8'h00;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            step();
            sel[d] = 1'b0; en[d] = 1'b0;
            quiet(d);
        end
    endtask

    // Full transfer; address/direction are scrambled after setup to prove latching.
    task automatic xfer(input int d, input logic w, input logic [8:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er);
        int   waits = (d == 0) ? 1 : 0;
        logic bad   = (a >= 9'd64);
        step();
        sel[d] = 1'b1; en[d] = 1'b0; wr[d] = w; addr[d] = a; wdata[d] = wd;
        quiet(d);
        for (int i = 0; i < waits; i++) begin
            step();
            en[d] = 1'b1; wr[d] = !w; addr[d] = a ^ 9'h1FF;
            quiet(d);
        end
        step();
        en[d] = 1'b1; wr[d] = !w; addr[d] = a ^ 9'h1FF;
        exp_rdy[d] = 1'b1;
        exp_err[d] = bad;
        exp_rd[d]  = (!w && !bad) ? mem_m[d][a[5:0]] : 8'h00;
        @(negedge clk);
        rd = prdata[d];
        er = perr[d];
        if (w && !bad) mem_m[d][a[5:0]] = wd;
    endtask

    logic [7:0] rd;
    logic       er;

    initial begin
        rst = 2'b11; sel = '0; en = '0; wr = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        exp_rdy = '0; exp_err = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) mem_m[d][i] = 8'h00;

        // 1: reset held for two edges, outputs idle, memory cleared
        @(posedge clk); @(posedge clk); #1;
        rst = 2'b00;
        chk = 1'b1;
        @(negedge clk);
        check("reset_pready", {7'd0, rdy0}, 8'h00);
        check("reset_pslverr", {7'd0, perr0}, 8'h00);
        check("reset_prdata", prdata[0], 8'h00);
        xfer(0, 1'b0, 9'h005, 8'h00, rd, er);
        check("reset_read05", rd, 8'h00);

        // 2: one wait state write then read
        xfer(0, 1'b1, 9'h005, 8'hAA, rd, er);
        xfer(0, 1'b0, 9'h005, 8'h00, rd, er);
        check("w1_read05", rd, 8'hAA);
        check("w1_read05_err", {7'd0, er}, 8'h00);
        idle(0, 1);

        // 3: zero-wait instance, back-to-back write/read at top address
        xfer(1, 1'b1, 9'h03F, 8'hFF, rd, er);
        xfer(1, 1'b0, 9'h03F, 8'h00, rd, er);
        check("w0_read3f", rd, 8'hFF);
        idle(1, 1);

        // 4: out-of-range write/read, then no aliasing onto 0x00
        xfer(0, 1'b1, 9'h000, 8'h12, rd, er);
        xfer(0, 1'b1, 9'h040, 8'hDE, rd, er);
        check("oor_write_err", {7'd0, er}, 8'h01);
        xfer(0, 1'b0, 9'h040, 8'h00, rd, er);
        check("oor_read_err", {7'd0, er}, 8'h01);
        check("oor_read_data", rd, 8'h00);
        xfer(0, 1'b0, 9'h1C0, 8'h00, rd, er);
        check("oor_high_err", {7'd0, er}, 8'h01);
        xfer(0, 1'b0, 9'h000, 8'h00, rd, er);
        check("no_alias00", rd, 8'h12);
        idle(0, 1);

        // 6: access phase without setup is ignored
        step();
        sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 9'h007; wdata[0] = 8'h99;
        quiet(0);
        step();
        quiet(0);
        idle(0, 1);
        xfer(0, 1'b0, 9'h007, 8'h00, rd, er);
        check("nosetup_read07", rd, 8'h00);

        // 5: abort during wait leaves memory untouched
        xfer(0, 1'b1, 9'h010, 8'h33, rd, er);
        step();
        sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 9'h010; wdata[0] = 8'h55;
        quiet(0);
        step();
        en[0] = 1'b1;
        quiet(0);
        idle(0, 1);
        xfer(0, 1'b0, 9'h010, 8'h00, rd, er);
        check("abort_read10", rd, 8'h33);

        // 5b: reset in the middle of an access drops the transfer and clears memory
        step();
        sel[0] = 1'b1; en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 9'h005; wdata[0] = 8'h77;
        quiet(0);
        step();
        en[0] = 1'b1; rst[0] = 1'b1;
        quiet(0);
        step();
        rst[0] = 1'b0; sel[0] = 1'b0; en[0] = 1'b0;
        quiet(0);
        for (int i = 0; i < 64; i++) mem_m[0][i] = 8'h00;
        xfer(0, 1'b0, 9'h005, 8'h00, rd, er);
        check("rst_read05", rd, 8'h00);
        xfer(0, 1'b0, 9'h000, 8'h00, rd, er);
        check("rst_read00", rd, 8'h00);
        for (int i = 0; i < 64; i++) xfer(0, 1'b0, 9'(i), 8'h00, rd, er);
        idle(0, 2);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
